// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit and its environment: instruction-memory port,
// decode-stage controls (stall/redirect) and the issued instruction.
interface fetch_unit_if;
    // imem_req/imem_ack: imem_req and imem_addr are held stable from the first
    // requesting cycle until the cycle in which imem_ack=1 is seen with
    // imem_req=1; that cycle completes the read and imem_rdata must be valid in
    // it. An imem_ack while imem_req=0 carries nothing and is ignored.
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic [31:0] ir;
    logic [3:0]  opcode;
    logic        ir_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        fetch_err;
    logic [1:0]  dbg_state;

    modport master (
        output imem_req, imem_addr, ir, opcode, ir_valid, pc, pc_plus1,
               fetch_err, dbg_state,
        input  imem_ack, imem_rdata, stall, redirect, redirect_addr
    );

    modport slave (
        input  imem_req, imem_addr, ir, opcode, ir_valid, pc, pc_plus1,
               fetch_err, dbg_state,
        output imem_ack, imem_rdata, stall, redirect, redirect_addr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch FSM (START/FETCH/ISSUE) with in-flight redirect squashing.
// Define FETCH_TIMEOUT_EN to add the fetch wait-timeout and sticky fetch_err.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam logic [1:0] START = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;

    // TIMEOUT must fit the 4-bit wait counter.
    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT must be in 1..15");
    end

    logic [1:0]  state_q, state_d;
    logic [15:0] fpc_q, fpc_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        squash_q, squash_d;
    logic [15:0] sq_addr_q, sq_addr_d;
    logic        req_w;
    logic        ack_seen;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       idle_q, idle_d;
    logic       fetch_err_q, fetch_err_d;

    assign req_w         = (state_q == FETCH) && !idle_q;
    assign bus.fetch_err = fetch_err_q;
`else
    assign req_w         = (state_q == FETCH);
    assign bus.fetch_err = 1'b0;
`endif

    assign ack_seen      = req_w && bus.imem_ack;
    assign bus.imem_req  = req_w;
    assign bus.imem_addr = fpc_q;
    assign bus.ir        = ir_q;
    assign bus.opcode    = ir_q[31:28];
    assign bus.ir_valid  = ir_valid_q;
    assign bus.pc        = pc_q;
    assign bus.pc_plus1  = pc_q + 16'd1;
    assign bus.dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        squash_d   = squash_q;
        sq_addr_d  = sq_addr_q;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        idle_d      = 1'b0;
        fetch_err_d = fetch_err_q;
`endif
        case (state_q)
            START: state_d = FETCH;
            FETCH: begin
                if (ack_seen) begin
                    // A redirect in the ack cycle squashes just like an earlier one,
                    // and the newest target wins.
                    if (squash_q || bus.redirect) begin
                        fpc_d    = bus.redirect ? bus.redirect_addr : sq_addr_q;
                        squash_d = 1'b0;
                    end else begin
                        ir_d       = bus.imem_rdata;
                        pc_d       = fpc_q;
                        ir_valid_d = 1'b1;
                        state_d    = ISSUE;
                    end
                end else if (bus.redirect) begin
                    squash_d  = 1'b1;
                    sq_addr_d = bus.redirect_addr;
                end
`ifdef FETCH_TIMEOUT_EN
                if (ack_seen) begin
                    wait_cnt_d = 4'd0;
                end else if (req_w) begin
                    if (wait_cnt_q == TIMEOUT_LAST) begin
                        wait_cnt_d  = 4'd0;
                        fetch_err_d = 1'b1;
                        idle_d      = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end
`endif
            end
            ISSUE: begin
                // While stalled, a pending redirect is held by decode until stall drops.
                if (!bus.stall) begin
                    fpc_d      = bus.redirect ? bus.redirect_addr : fpc_q + 16'd1;
                    ir_valid_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= START;
            fpc_q      <= RESET_PC;
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0;
            ir_valid_q <= 1'b0;
            squash_q   <= 1'b0;
            sq_addr_q  <= 16'h0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q  <= 4'd0;
            idle_q      <= 1'b0;
            fetch_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            squash_q   <= squash_d;
            sq_addr_q  <= sq_addr_d;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            idle_q      <= idle_d;
            fetch_err_q <= fetch_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a default instance plus one with
// RESET_PC=16'hFFFF for address wrap-around.
module tb_fetch_unit;

    logic clk;
    logic rst;

    fetch_unit_if fif();
    fetch_unit_if wif();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (fif)
    );

    fetch_unit #(.RESET_PC(16'hFFFF)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (wif)
    );

    int vectors;
    int miscompares;
    logic [47:0] exp_q[$];
    logic [15:0] exp_fpc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_req(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (fif.imem_req === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL wait_req: imem_req=%b after %0d cycles, required 1", fif.imem_req, budget);
        end else begin
            vectors++;
            if (fif.ir_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL fetch_ir_valid: got %b, expected 0", fif.ir_valid);
            end
        end
    endtask

    task automatic ack_and_check(input logic [31:0] data);
        logic [47:0] exp;
        logic [15:0] exp_pc;
        logic [31:0] exp_ir;
        vectors++;
        if (fif.imem_addr !== exp_fpc) begin
            miscompares++;
            $display("FAIL imem_addr: got %h, expected %h", fif.imem_addr, exp_fpc);
        end
        fif.imem_ack   = 1'b1;
        fif.imem_rdata = data;
        exp_q.push_back({exp_fpc, data});
        @(negedge clk);
        fif.imem_ack   = 1'b0;
        fif.imem_rdata = 32'h0;
        vectors++;
        if (fif.ir_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_ir_valid: got %b, expected 1", fif.ir_valid);
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: queue empty, expected an entry");
        end else begin
            exp    = exp_q.pop_front();
            exp_pc = exp[47:32];
            exp_ir = exp[31:0];
            if (fif.pc !== exp_pc || fif.ir !== exp_ir || fif.opcode !== exp_ir[31:28]
                || fif.pc_plus1 !== exp_pc + 16'd1) begin
                miscompares++;
                $display("FAIL issue: got pc=%h ir=%h op=%h pc1=%h, expected pc=%h ir=%h op=%h pc1=%h",
                         fif.pc, fif.ir, fif.opcode, fif.pc_plus1,
                         exp_pc, exp_ir, exp_ir[31:28], exp_pc + 16'd1);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (fif.imem_req !== 1'b0 || fif.ir_valid !== 1'b0 || fif.pc !== 16'h0000
            || fif.ir !== 32'h0 || fif.fetch_err !== 1'b0 || fif.dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset: got req=%b v=%b pc=%h ir=%h err=%b st=%0d, expected 0 0 0000 0 0 0",
                     fif.imem_req, fif.ir_valid, fif.pc, fif.ir, fif.fetch_err, fif.dbg_state);
        end
        vectors++;
        if (wif.pc !== 16'hFFFF || wif.imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_w: got pc=%h req=%b, expected ffff 0", wif.pc, wif.imem_req);
        end
        rst     = 1'b0;
        exp_fpc = 16'h0000;
    endtask

    task automatic test_sequential;
        for (int i = 0; i < 3; i++) begin
            wait_req(8);
            ack_and_check(32'h1000_0000 | 32'($urandom_range(0, 16'hFFFF)));
            exp_fpc = exp_fpc + 16'd1;
        end
    endtask

    task automatic test_stall;
        logic [15:0] held_pc;
        wait_req(8);
        fif.stall = 1'b1;
        held_pc   = exp_fpc;
        ack_and_check(32'h4123_0005);
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (fif.ir !== 32'h4123_0005 || fif.opcode !== 4'h4 || fif.pc !== held_pc
                || fif.imem_req !== 1'b0 || fif.ir_valid !== 1'b1 || fif.dbg_state !== 2'd2) begin
                miscompares++;
                $display("FAIL stall_hold: got ir=%h op=%h pc=%h req=%b v=%b st=%0d, expected 41230005 4 %h 0 1 2",
                         fif.ir, fif.opcode, fif.pc, fif.imem_req, fif.ir_valid, fif.dbg_state, held_pc);
            end
        end
        fif.stall = 1'b0;
        exp_fpc   = held_pc + 16'd1;
        wait_req(8);
        ack_and_check(32'h7000_0077);
        exp_fpc = exp_fpc + 16'd1;
    endtask

    task automatic test_redirect_issue;
        wait_req(8);
        ack_and_check(32'h2000_0011);
        fif.stall         = 1'b1;
        fif.redirect      = 1'b1;
        fif.redirect_addr = 16'h0040;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (fif.ir_valid !== 1'b1 || fif.imem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL redirect_stalled: got v=%b req=%b, expected 1 0", fif.ir_valid, fif.imem_req);
            end
        end
        fif.stall = 1'b0;
        exp_fpc   = 16'h0040;
        @(negedge clk);
        fif.redirect      = 1'b0;
        fif.redirect_addr = 16'h0;
        vectors++;
        if (fif.imem_req !== 1'b1 || fif.ir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_fetch: got req=%b v=%b, expected 1 0", fif.imem_req, fif.ir_valid);
        end
        ack_and_check(32'h3000_0040);
        exp_fpc = exp_fpc + 16'd1;
    endtask

    task automatic test_redirect_inflight;
        logic [15:0] stale;
        wait_req(8);
        stale             = exp_fpc;
        fif.redirect      = 1'b1;
        fif.redirect_addr = 16'h0080;
        @(negedge clk);
        fif.redirect = 1'b0;
        repeat (2) begin
            vectors++;
            if (fif.imem_addr !== stale || fif.imem_req !== 1'b1) begin
                miscompares++;
                $display("FAIL inflight_hold: got addr=%h req=%b, expected %h 1", fif.imem_addr, fif.imem_req, stale);
            end
            @(negedge clk);
        end
        fif.imem_ack   = 1'b1;
        fif.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        fif.imem_ack = 1'b0;
        vectors++;
        if (fif.ir_valid !== 1'b0 || fif.imem_req !== 1'b1 || fif.imem_addr !== 16'h0080) begin
            miscompares++;
            $display("FAIL inflight_squash: got v=%b req=%b addr=%h, expected 0 1 0080",
                     fif.ir_valid, fif.imem_req, fif.imem_addr);
        end
        exp_fpc = 16'h0080;
        ack_and_check(32'h5000_0080);
        exp_fpc = exp_fpc + 16'd1;

        wait_req(8);
        fif.imem_ack      = 1'b1;
        fif.imem_rdata    = 32'hBAD0_0BAD;
        fif.redirect      = 1'b1;
        fif.redirect_addr = 16'h00C0;
        @(negedge clk);
        fif.imem_ack = 1'b0;
        fif.redirect = 1'b0;
        vectors++;
        if (fif.ir_valid !== 1'b0 || fif.imem_req !== 1'b1 || fif.imem_addr !== 16'h00C0) begin
            miscompares++;
            $display("FAIL ack_redirect: got v=%b req=%b addr=%h, expected 0 1 00c0",
                     fif.ir_valid, fif.imem_req, fif.imem_addr);
        end
        exp_fpc = 16'h00C0;
        ack_and_check(32'h6000_00C0);
        exp_fpc = exp_fpc + 16'd1;
    endtask

    task automatic test_timeout;
        wait_req(8);
`ifdef FETCH_TIMEOUT_EN
        for (int i = 1; i < 15; i++) begin
            @(negedge clk);
            vectors++;
            if (fif.imem_req !== 1'b1 || fif.fetch_err !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_wait[%0d]: got req=%b err=%b, expected 1 0", i, fif.imem_req, fif.fetch_err);
            end
        end
        @(negedge clk);
        vectors++;
        if (fif.imem_req !== 1'b0 || fif.fetch_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_idle: got req=%b err=%b, expected 0 1", fif.imem_req, fif.fetch_err);
        end
        @(negedge clk);
        vectors++;
        if (fif.imem_req !== 1'b1 || fif.imem_addr !== exp_fpc || fif.fetch_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_retry: got req=%b addr=%h err=%b, expected 1 %h 1",
                     fif.imem_req, fif.imem_addr, fif.fetch_err, exp_fpc);
        end
`else
        repeat (20) begin
            @(negedge clk);
            vectors++;
            if (fif.imem_req !== 1'b1 || fif.imem_addr !== exp_fpc || fif.fetch_err !== 1'b0) begin
                miscompares++;
                $display("FAIL no_timeout: got req=%b addr=%h err=%b, expected 1 %h 0",
                         fif.imem_req, fif.imem_addr, fif.fetch_err, exp_fpc);
            end
        end
`endif
        ack_and_check(32'h8000_0008);
        exp_fpc = exp_fpc + 16'd1;
    endtask

    task automatic test_wrap;
        logic [15:0] addrs[2];
        logic [47:0] exp;
        addrs[0] = 16'hFFFF;
        addrs[1] = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            bit seen;
            logic [31:0] data;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (wif.imem_req === 1'b1) seen = 1'b1;
            end
            vectors++;
            if (!seen || wif.imem_addr !== addrs[k]) begin
                miscompares++;
                $display("FAIL wrap_addr[%0d]: got req=%b addr=%h, expected 1 %h", k, wif.imem_req, wif.imem_addr, addrs[k]);
            end
            data           = 32'h9000_0000 | 32'($urandom_range(0, 255));
            wif.imem_ack   = 1'b1;
            wif.imem_rdata = data;
            exp_q.push_back({addrs[k], data});
            @(negedge clk);
            wif.imem_ack = 1'b0;
            exp          = exp_q.pop_front();
            vectors++;
            if (wif.ir_valid !== 1'b1 || wif.pc !== exp[47:32] || wif.ir !== exp[31:0]
                || wif.pc_plus1 !== exp[47:32] + 16'd1) begin
                miscompares++;
                $display("FAIL wrap_issue[%0d]: got v=%b pc=%h ir=%h pc1=%h, expected 1 %h %h %h",
                         k, wif.ir_valid, wif.pc, wif.ir, wif.pc_plus1, exp[47:32], exp[31:0], exp[47:32] + 16'd1);
            end
        end
    endtask

    task automatic test_reset_midfetch;
        wait_req(8);
        rst               = 1'b1;
        fif.imem_ack      = 1'b1;
        fif.imem_rdata    = 32'hFFFF_0000;
        fif.redirect      = 1'b1;
        fif.redirect_addr = 16'h1234;
        fif.stall         = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        fif.redirect = 1'b0;
        fif.stall    = 1'b0;
        vectors++;
        if (fif.dbg_state !== 2'd0 || fif.imem_req !== 1'b0 || fif.ir_valid !== 1'b0
            || fif.pc !== 16'h0000 || fif.ir !== 32'h0 || fif.fetch_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midfetch_reset: got st=%0d req=%b v=%b pc=%h ir=%h err=%b, expected 0 0 0 0000 0 0",
                     fif.dbg_state, fif.imem_req, fif.ir_valid, fif.pc, fif.ir, fif.fetch_err);
        end
        @(negedge clk);
        fif.imem_ack = 1'b0;
        vectors++;
        if (fif.dbg_state !== 2'd1 || fif.imem_req !== 1'b1 || fif.ir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL late_ack: got st=%0d req=%b v=%b, expected 1 1 0", fif.dbg_state, fif.imem_req, fif.ir_valid);
        end
        exp_fpc = 16'h0000;
        ack_and_check(32'hA000_0000);
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        rst               = 1'b1;
        fif.imem_ack      = 1'b0;
        fif.imem_rdata    = 32'h0;
        fif.stall         = 1'b0;
        fif.redirect      = 1'b0;
        fif.redirect_addr = 16'h0;
        wif.imem_ack      = 1'b0;
        wif.imem_rdata    = 32'h0;
        wif.stall         = 1'b0;
        wif.redirect      = 1'b0;
        wif.redirect_addr = 16'h0;

        test_reset();
        test_sequential();
        test_stall();
        test_redirect_issue();
        test_redirect_inflight();
        test_timeout();
        test_wrap();
        test_reset_midfetch();

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter RESET_PC, default 16'h0000: the fetch address loaded at reset.
REQ-003 Parameter TIMEOUT, default 15: the number of wait cycles before a fetch timeout (used only with FETCH_TIMEOUT_EN).
REQ-004 Port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port imem_req, output, 1 bit: instruction memory read request.
REQ-007 Port imem_addr, output, 16 bits: instruction word address.
REQ-008 Port imem_ack, input, 1 bit: read data valid this cycle.
REQ-009 Port imem_rdata, input, 32 bits: instruction word.
REQ-010 Port stall, input, 1 bit: the downstream decode stage cannot accept a new instruction.
REQ-011 Port redirect, input, 1 bit: a taken jump or branch; the next fetch comes from redirect_addr.
REQ-012 Port redirect_addr, input, 16 bits: the jump or branch target.
REQ-013 Port ir, output, 32 bits: the held instruction.
REQ-014 Port opcode, output, 4 bits: ir[31:28], driven to the control decoder.
REQ-015 Port ir_valid, output, 1 bit: ir holds a live instruction.
REQ-016 Port pc, output, 16 bits: the address of the instruction in ir.
REQ-017 Port pc_plus1, output, 16 bits: pc+1, for branch-offset computation downstream.
REQ-018 Port fetch_err, output, 1 bit: sticky timeout flag (only with FETCH_TIMEOUT_EN).

Function
REQ-019 The FSM SHALL have exactly three states: START, FETCH and ISSUE.
REQ-020 START SHALL always transition to FETCH on the next cycle, with imem_req=0.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal the fetch pointer fpc.
- imem_addr and imem_req hold stable until imem_ack.
REQ-022 In FETCH, imem_ack with no pending squash SHALL load ir with imem_rdata, set pc to fpc and ir_valid to 1, and move to ISSUE.
- Latency: ack cycle to ir_valid = 1 cycle.
REQ-023 In ISSUE, imem_req SHALL be 0 and ir, pc and ir_valid SHALL hold while stall=1.
REQ-024 In ISSUE with stall=0, the block SHALL set fpc to redirect ? redirect_addr : fpc+1, clear ir_valid, and move to FETCH.
REQ-025 If redirect and stall are both 1 in ISSUE, redirect SHALL be ignored; the downstream stage keeps it asserted until stall drops.
REQ-026 If redirect=1 during FETCH, fpc SHALL NOT change until ack; the squash flag SHALL be set and redirect_addr latched.
REQ-027 An imem_ack arriving with squash=1 SHALL discard the data, leave ir_valid at 0, load fpc from the latched address, clear squash, and remain in FETCH.
- A new request goes out on the next cycle.
REQ-028 redirect and imem_ack in the same FETCH cycle SHALL be treated as squash-on-ack: the data is discarded and fpc is set to redirect_addr.
REQ-029 fpc+1 SHALL wrap from 16'hFFFF to 16'h0000 with no flag, and pc_plus1 SHALL wrap the same way.
REQ-030 opcode SHALL be a combinational slice of ir; it is ir[31:28] even when ir_valid=0.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL set state=START, fpc=RESET_PC, pc=RESET_PC, ir=32'h0, ir_valid=0, squash=0, imem_req=0 and fetch_err=0.
REQ-032 Reset mid-fetch SHALL abandon the outstanding request.
- A late imem_ack after reset is ignored, because the block is in START.
REQ-033 Reset SHALL take priority over stall, redirect and imem_ack.

Configuration
REQ-034 When macro FETCH_TIMEOUT_EN is defined, a 4-bit wait counter SHALL count FETCH cycles without ack.
- On reaching TIMEOUT, fetch_err is set to 1 (sticky until rst), the counter clears, imem_req drops for one cycle, and then the same fpc is re-requested.
REQ-035 When FETCH_TIMEOUT_EN is undefined, no counter SHALL exist, fetch_err SHALL be tied to 0, and FETCH SHALL wait indefinitely.

Verification
REQ-036 The bench SHALL cover reset then immediate ack: rst high for 2 cycles, ack every request -> imem_addr sequence 0,1,2 with ir_valid high one cycle after each ack; pc = 0,1,2.
REQ-037 The bench SHALL cover a stall: stall=1 for 3 cycles in ISSUE with ir=32'h4123_0005 -> ir, opcode=4'h4 and pc all held, imem_req=0, and the next fetch addr = pc+1.
REQ-038 The bench SHALL cover a redirect in ISSUE: redirect=1, redirect_addr=16'h0040 -> next imem_addr=16'h0040 and the following pc=16'h0040.
REQ-039 The bench SHALL cover a redirect in flight: redirect to 16'h0080 while waiting 3 cycles for ack -> the acked word is discarded (ir_valid stays 0) and the next request is addr 16'h0080.
REQ-040 The bench SHALL cover wrap-around: RESET_PC=16'hFFFF, sequential fetch -> addresses FFFF then 0000; pc_plus1=16'h0000 while pc=FFFF.
REQ-041 The bench SHALL cover timeout with FETCH_TIMEOUT_EN: withhold ack 15 cycles -> fetch_err=1, one idle cycle, the same address re-requested; without the macro, fetch_err stays 0.
